// File: rtl/data_mem_ctrl.sv
// Data-memory controller: valid/ready request port, fixed-latency response,
// byte-lane load/store and misalignment/range error reporting.
module data_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              err_misalign,
    output logic              err_range
);
    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   count, count_d;
    logic [DATA_W-1:0]  mem [0:DEPTH-1];

    logic [OFS_W-1:0]   lane;
    logic [IDX_W-1:0]   idx;
    logic               mis, rng, accept, wr_ok;
    logic [DATA_W-1:0]  rd_word, load_data;
    logic [7:0]         rd_byte;
    logic [DATA_W-1:0]  rdata_q;
    logic               mis_q, rng_q;

    assign lane   = req_addr[OFS_W-1:0];
    assign idx    = req_addr[OFS_W +: IDX_W];
    assign mis    = !req_byte && (lane != '0);
    // Any address bit above the index field is out of range, as is an index past DEPTH.
    assign rng    = (32'(idx) >= DEPTH) || ((req_addr >> (OFS_W + IDX_W)) != 32'd0);
    assign accept = req_valid && req_ready;
    assign wr_ok  = accept && req_we && !mis && !rng;

    assign rd_word   = mem[idx];
    assign rd_byte   = rd_word[{lane, 3'b000} +: 8];
    assign load_data = (req_we || mis || rng) ? '0 :
                       req_byte ? {{(DATA_W-8){1'b0}}, rd_byte} : rd_word;

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (req_byte)
                mem[idx][{lane, 3'b000} +: 8] <= req_wdata[7:0];
            else
                mem[idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= load_data;
            mis_q   <= mis;
            rng_q   <= rng;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        case (state)
            IDLE: if (accept) begin
                count_d = CNT_W'(LATENCY - 1);
                state_d = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                count_d = count - 1'b1;
                if (count == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready    = (state == IDLE) && rst;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        err_misalign = 1'b0;
        err_range    = 1'b0;
        if (state == RESP) begin
            rsp_valid    = 1'b1;
            rsp_rdata    = rdata_q;
            err_misalign = mis_q;
            err_range    = rng_q;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: four instances (LATENCY 1..4) sharing a clock,
// responses scored against a queue of expected results.
module tb_data_mem_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int NI     = 4;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] rdata;
        logic        mis;
        logic        rng;
    } exp_t;

    logic              clk = 0;
    logic [NI-1:0]     rst;
    logic [NI-1:0]     req_valid, req_ready, req_we, req_byte;
    logic [31:0]       req_addr  [NI];
    logic [DATA_W-1:0] req_wdata [NI];
    logic [NI-1:0]     rsp_valid, err_misalign, err_range;
    logic [DATA_W-1:0] rsp_rdata [NI];

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(i + 1)) u_dut (
            .clk          (clk),
            .rst          (rst[i]),
            .req_valid    (req_valid[i]),
            .req_ready    (req_ready[i]),
            .req_we       (req_we[i]),
            .req_byte     (req_byte[i]),
            .req_addr     (req_addr[i]),
            .req_wdata    (req_wdata[i]),
            .rsp_valid    (rsp_valid[i]),
            .rsp_rdata    (rsp_rdata[i]),
            .err_misalign (err_misalign[i]),
            .err_range    (err_range[i])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic mem_wr(input int k, input int a, input logic [31:0] v);
        case (k)
            0: g_dut[0].u_dut.mem[a] = v;
            1: g_dut[1].u_dut.mem[a] = v;
            2: g_dut[2].u_dut.mem[a] = v;
            default: g_dut[3].u_dut.mem[a] = v;
        endcase
    endtask

    function automatic logic [31:0] mem_rd(input int k, input int a);
        case (k)
            0: return g_dut[0].u_dut.mem[a];
            1: return g_dut[1].u_dut.mem[a];
            2: return g_dut[2].u_dut.mem[a];
            default: return g_dut[3].u_dut.mem[a];
        endcase
    endfunction

    // Scoreboard monitor: every response must match the oldest expectation,
    // including the cycle it shows up in; outside responses outputs must be 0.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rsp_valid[k]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_inst", 32'(k), 32'(e.inst));
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_rdata", rsp_rdata[k], e.rdata);
                    chk("rsp_mis", 32'(err_misalign[k]), 32'(e.mis));
                    chk("rsp_rng", 32'(err_range[k]), 32'(e.rng));
                end
            end else begin
                chk("idle_outputs", rsp_rdata[k] | 32'(err_misalign[k]) | 32'(err_range[k]), 32'd0);
            end
        end
    end

    // Issue one request on instance k; returns the acceptance edge number.
    task automatic do_req(input int k, input logic we, input logic by, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] e_rd, input logic e_mis,
                          input logic e_rng, input logic hold, output int t_acc);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_we[k] = we; req_byte[k] = by; req_addr[k] = addr; req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid[k] = 1'b0;
            t_acc = -1;
            return;
        end
        t_acc  = cyc + 1;
        e.inst = k; e.cyc = cyc + k + 1; e.rdata = e_rd; e.mis = e_mis; e.rng = e_rng;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) req_valid[k] = 1'b0;
        @(negedge clk);
        chk("ready_low_after_accept", 32'(req_ready[k]), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t, t0, t1, t2;
        rst = '0; req_valid = '0; req_we = '0; req_byte = '0;
        for (int k = 0; k < NI; k++) begin
            req_addr[k] = '0;
            req_wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_ready", 32'(req_ready[k]), 32'd0);
            chk("reset_valid", 32'(rsp_valid[k]), 32'd0);
        end
        rst = '1;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'hF);

        // LATENCY=1 sequential loads
        for (int i = 0; i < 5; i++) mem_wr(0, i, 32'((i + 1) * 10));
        for (int i = 0; i < 5; i++) do_req(0, 0, 0, 32'(4 * i), 32'h0, 32'((i + 1) * 10), 0, 0, 0, t);
        drain();

        // LATENCY=3 store then load
        do_req(2, 1, 0, 32'd8, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, t);
        drain();
        do_req(2, 0, 0, 32'd8, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, t);
        drain();

        // Byte path
        mem_wr(2, 1, 32'h1122_3344);
        do_req(2, 1, 1, 32'd5, 32'hFFFF_FFAA, 32'd0, 0, 0, 0, t);
        drain();
        chk("byte_store_mem", mem_rd(2, 1), 32'h1122_AA44);
        do_req(2, 0, 1, 32'd7, 32'h0, 32'h0000_0011, 0, 0, 0, t);
        do_req(2, 0, 0, 32'd4, 32'h0, 32'h1122_AA44, 0, 0, 0, t);
        drain();

        // Errors
        mem_wr(2, 0, 32'hA1B2_C3D4);
        do_req(2, 0, 0, 32'd6, 32'h0, 32'd0, 1, 0, 0, t);
        do_req(2, 1, 0, 32'(4 * DEPTH), 32'hFFFF_FFFF, 32'd0, 0, 1, 0, t);
        do_req(2, 1, 0, 32'd2, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, t);
        do_req(2, 1, 1, 32'(4 * DEPTH + 1), 32'h0000_00EE, 32'd0, 0, 1, 0, t);
        do_req(2, 0, 0, 32'(4 * DEPTH + 2), 32'h0, 32'd0, 1, 1, 0, t);
        do_req(2, 0, 1, 32'd3, 32'h0, 32'h0000_00A1, 0, 0, 0, t);
        drain();
        chk("errored_store_no_write", mem_rd(2, 0), 32'hA1B2_C3D4);

        // Reset mid-operation, LATENCY=4
        mem_wr(3, 2, 32'h1234_5678);
        do_req(3, 1, 0, 32'd12, 32'hCAFE_F00D, 32'd0, 0, 0, 0, t);
        void'(sb.pop_back());
        @(posedge clk);
        #1 rst[3] = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(req_ready[3]), 32'd0);
        chk("rst_mid_outputs", 32'(rsp_valid[3]) | rsp_rdata[3] | 32'(err_misalign[3]) | 32'(err_range[3]), 32'd0);
        chk("committed_store", mem_rd(3, 3), 32'hCAFE_F00D);
        @(negedge clk);
        rst[3] = 1'b1;
        #1;
        chk("ready_after_release", 32'(req_ready[3]), 32'd1);
        do_req(3, 0, 0, 32'd8, 32'h0, 32'h1234_5678, 0, 0, 0, t);
        void'(sb.pop_back());
        @(posedge clk);
        #1 rst[3] = 1'b0;
        @(negedge clk);
        rst[3] = 1'b1;
        repeat (8) @(negedge clk);

        // Back-to-back with req_valid held, LATENCY=2
        for (int i = 0; i < 3; i++) mem_wr(1, i, 32'h100 + 32'(i));
        do_req(1, 0, 0, 32'd0, 32'h0, 32'h100, 0, 0, 1, t0);
        do_req(1, 0, 0, 32'd4, 32'h0, 32'h101, 0, 0, 1, t1);
        do_req(1, 0, 0, 32'd8, 32'h0, 32'h102, 0, 0, 0, t2);
        drain();
        chk("b2b_spacing_1", 32'(t1 - t0), 32'd3);
        chk("b2b_spacing_2", 32'(t2 - t1), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
